alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Decode/operand-fetch stage directly upstream of the ALU. Accepts an RV32I instruction word,
//  decodes OP, OP-IMM and LUI, reads rs1/rs2 from an internal register file and registers
//  fn/funct7/a/b for the ALU. Also registers rd and an illegal flag for the stages below.
//  Uses a valid/ready handshake. One pipeline register sits between the fetch side and the ALU.
// PARAMETERS
//  WIDTH    32  data/register width; only 32 is supported; elaboration error otherwise
//  NREGS    32  architectural registers; x0 reads as 0
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      instr is valid this cycle
//  in_ready    out  1      stage can accept instr this cycle
//  instr       in   32     RV32I instruction word
//  wb_en       in   1      writeback strobe
//  wb_rd       in   5      writeback destination register
//  wb_data     in   WIDTH  writeback value
//  out_valid   out  1      registered ALU operands are valid
//  out_ready   in   1      downstream (ALU/EX) consumes this cycle
//  fn          out  3      ALU function (funct3 encoding, ALU_FN enum)
//  funct7      out  7      ALU funct7 qualifier (bit 5 = SUB/SRA)
//  a           out  WIDTH  ALU operand A
//  b           out  WIDTH  ALU operand B
//  rd          out  5      destination register of the buffered instruction
//  illegal     out  1      buffered instruction is not a supported encoding
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0; fn, funct7, a, b, rd and illegal all 0; all regfile entries 0.
//  - in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
//  - On accept, all outputs load on the same edge: latency 1 cycle, throughput 1/cycle.
//  - out_valid: set on accept; cleared on out_ready without accept; held otherwise.
//  - While out_valid && !out_ready, all outputs hold stable.
//  - OP (0110011): fn=funct3, funct7=instr[31:25], a=R[rs1], b=R[rs2].
//  - OP-IMM (0010011): fn=funct3, a=R[rs1], b=sext(instr[31:20]).
//      funct7=instr[31:25] for SLLI/SRLI/SRAI (funct3 001/101); funct7=0 otherwise.
//  - LUI (0110111): fn=ADD, funct7=0, a=0, b={instr[31:12],12'b0}.
//  - illegal=1 when: opcode not one of the three above; OP with funct7 not in {0000000,0100000};
//    OP with funct7=0100000 and funct3 not ADD/SRL; SLLI with funct7!=0; SRLI/SRAI with funct7
//    not in {0000000,0100000}. Illegal instructions still flow (out_valid=1) with fn=0, funct7=0,
//    a=0, b=0, rd=instr[11:7].
//  - Regfile: 2 async read ports, 1 write port on the clock edge. A write to x0 is discarded.
//    Reads of x0 return 0.
//  - Bypass: at accept, if wb_en && wb_rd!=0 && wb_rd==rs1 (or rs2), the operand is wb_data.
//  - Operands are sampled at accept only. A later writeback does not update a buffered operand.
//    Hazard stalling belongs to the hazard unit.
//  - wb writes proceed every cycle regardless of the handshake state.
//  - Reset mid-operation: the buffered instruction is dropped and the regfile is cleared.
// STRUCTURE
//  - Shared package RV_PKG: opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI; funct7 constants
//    F7_BASE=7'b0000000, F7_ALT=7'b0100000; instr field-slice helper functions.
//  - ALU_FN package: supplies fn values (ADD, AND, ...). It is not redefined here.
//  - Sub-module regfile (#(WIDTH, NREGS)): async-reset array, 2R1W, x0 hardwired to 0.
//    Bypass muxing lives in alu_operand_stage.
//  - Decode is combinational; a single output register bank holds the results.
// TESTING
//  1. Reset, then write x1=23 and x2=11 via wb. Send AND x3,x1,x2 (0x0020F1B3), out_ready=1.
//     -> Next cycle: out_valid=1, fn=AND, a=23, b=11, funct7=0, rd=3.
//  2. ADDI x5,x1,-1 (0xFFF08293). -> b=32'hFFFFFFFF, funct7=0, fn=ADD.
//     SRAI x5,x1,3 (0x4030D293). -> funct7=0100000, b=32'h403.
//  3. Same-cycle bypass: wb_en=1, wb_rd=1, wb_data=99 in the accept cycle of ADD x4,x1,x1.
//     -> a=99, b=99. With wb_rd=0 instead -> the write is discarded and x0 still reads 0.
//  4. Backpressure: out_ready=0 for 3 cycles with in_valid=1. -> in_ready=0; outputs are stable.
//     Raising out_ready -> the next instr is accepted in that cycle and nothing is lost or duplicated.
//  5. Illegal: instr=0x0000007F -> illegal=1 with fn/a/b=0.
//     OP with funct7=0100000 and funct3=AND -> illegal=1.
//  6. Assert rst_n=0 while out_valid=1 and out_ready=0. -> out_valid=0 immediately (async).
//     A read of x1 afterwards -> 0.

Source files
------------

// File: rtl/alu_operand_stage_pkg.sv
// Shared RV32I decode definitions for the operand stage: opcodes, funct7
// qualifiers, ALU function codes and instruction field helpers.
package alu_operand_stage_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU function codes follow the RV32I funct3 encoding so OP/OP-IMM map 1:1.
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SRL  = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_fn_e;

  function automatic logic [6:0] instr_opcode(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [4:0] instr_rd(input logic [31:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [2:0] instr_funct3(input logic [31:0] instr);
    return instr[14:12];
  endfunction

  function automatic logic [4:0] instr_rs1(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] instr_rs2(input logic [31:0] instr);
    return instr[24:20];
  endfunction

  function automatic logic [6:0] instr_funct7(input logic [31:0] instr);
    return instr[31:25];
  endfunction

  // Sign-extended I-type immediate.
  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  // U-type immediate, already shifted into the upper 20 bits.
  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

endpackage

// File: rtl/alu_operand_stage_regfile.sv
// Architectural register file: two asynchronous read ports, one write port
// on the rising edge, x0 hardwired to zero, whole array cleared on reset.
module alu_operand_stage_regfile #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [4:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [4:0]       raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [4:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] regs_q [NREGS];

  // Write port; writes to x0 are dropped so entry 0 stays zero forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != 5'd0) && (int'(waddr) < NREGS)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Asynchronous read ports; x0 is forced to zero independent of storage.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if ((raddr_a != 5'd0) && (int'(raddr_a) < NREGS)) begin
      rdata_a = regs_q[raddr_a];
    end
    if ((raddr_b != 5'd0) && (int'(raddr_b) < NREGS)) begin
      rdata_b = regs_q[raddr_b];
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Decode / operand-fetch stage feeding the ALU. Decodes OP, OP-IMM and LUI,
// reads operands with writeback bypass and holds them in one output register
// bank behind a valid/ready handshake.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       fn,
  output logic [6:0]       funct7,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [4:0]       rd,
  output logic             illegal
);

  if (WIDTH != 32) begin : g_width_check
    $error("alu_operand_stage: only WIDTH=32 is supported");
  end

  logic [6:0]       opc;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [WIDTH-1:0] rf_a;
  logic [WIDTH-1:0] rf_b;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             accept;

  alu_fn_e          fn_d,      fn_q;
  logic [6:0]       funct7_d,  funct7_q;
  logic [WIDTH-1:0] a_d,       a_q;
  logic [WIDTH-1:0] b_d,       b_q;
  logic             illegal_d, illegal_q;
  logic [4:0]       rd_q;
  logic             valid_d,   valid_q;

  assign opc = instr_opcode(instr);
  assign f3  = instr_funct3(instr);
  assign f7  = instr_funct7(instr);
  assign rs1 = instr_rs1(instr);
  assign rs2 = instr_rs2(instr);

  alu_operand_stage_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .waddr   (wb_rd),
    .wdata   (wb_data),
    .raddr_a (rs1),
    .rdata_a (rf_a),
    .raddr_b (rs2),
    .rdata_b (rf_b)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Same-cycle writeback bypass so an operand written this cycle is not stale.
  always_comb begin
    op_a = rf_a;
    op_b = rf_b;
    if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs1)) begin
      op_a = wb_data;
    end
    if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs2)) begin
      op_b = wb_data;
    end
  end

  // Instruction decode; illegal encodings are flattened to all-zero ALU fields.
  always_comb begin
    fn_d      = ALU_ADD;
    funct7_d  = F7_BASE;
    a_d       = '0;
    b_d       = '0;
    illegal_d = 1'b0;
    case (opc)
      OPC_OP: begin
        fn_d      = alu_fn_e'(f3);
        funct7_d  = f7;
        a_d       = op_a;
        b_d       = op_b;
        illegal_d = !((f7 == F7_BASE) ||
                      ((f7 == F7_ALT) && ((f3 == ALU_ADD) || (f3 == ALU_SRL))));
      end
      OPC_OP_IMM: begin
        fn_d = alu_fn_e'(f3);
        a_d  = op_a;
        b_d  = imm_i(instr);
        if (f3 == ALU_SLL) begin
          funct7_d  = f7;
          illegal_d = (f7 != F7_BASE);
        end else if (f3 == ALU_SRL) begin
          funct7_d  = f7;
          illegal_d = !((f7 == F7_BASE) || (f7 == F7_ALT));
        end
      end
      OPC_LUI: begin
        b_d = imm_u(instr);
      end
      default: begin
        illegal_d = 1'b1;
      end
    endcase
    if (illegal_d) begin
      fn_d     = ALU_ADD;
      funct7_d = F7_BASE;
      a_d      = '0;
      b_d      = '0;
    end
  end

  // Valid flag: set on accept, cleared when consumed without a replacement.
  always_comb begin
    valid_d = valid_q;
    if (accept) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register bank; loads only on accept so operands hold during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      fn_q      <= ALU_ADD;
      funct7_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        fn_q      <= fn_d;
        funct7_q  <= funct7_d;
        a_q       <= a_d;
        b_q       <= b_d;
        rd_q      <= instr_rd(instr);
        illegal_q <= illegal_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign fn        = fn_q;
  assign funct7    = funct7_q;
  assign a         = a_q;
  assign b         = b_q;
  assign rd        = rd_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: expected ALU fields are queued
// when an instruction is sent and compared when the stage hands them over.
module tb_alu_operand_stage;

  typedef struct packed {
    logic [2:0]  fn;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic [31:0] instr;
  logic        wbEn;
  logic [4:0]  wbRd;
  logic [31:0] wbData;
  logic        outValid;
  logic        outReady;
  logic [2:0]  fnO;
  logic [6:0]  funct7O;
  logic [31:0] aO;
  logic [31:0] bO;
  logic [4:0]  rdO;
  logic        illegalO;

  int   tests  = 0;
  int   failed = 0;
  exp_t sbQ[$];

  alu_operand_stage #(
    .WIDTH (32),
    .NREGS (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .instr     (instr),
    .wb_en     (wbEn),
    .wb_rd     (wbRd),
    .wb_data   (wbData),
    .out_valid (outValid),
    .out_ready (outReady),
    .fn        (fnO),
    .funct7    (funct7O),
    .a         (aO),
    .b         (bO),
    .rd        (rdO),
    .illegal   (illegalO)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge and let them settle.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic rdy,
                               input logic wbe, input logic [4:0] wbr, input logic [31:0] wbd);
    @(negedge clk);
    inValid  = v;
    instr    = ins;
    outReady = rdy;
    wbEn     = wbe;
    wbRd     = wbr;
    wbData   = wbd;
    #1;
  endtask

  function automatic exp_t mkExp(input logic [2:0] fn, input logic [6:0] f7, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd, input logic ill);
    exp_t e;
    e.fn  = fn;
    e.f7  = f7;
    e.a   = a;
    e.b   = b;
    e.rd  = rd;
    e.ill = ill;
    return e;
  endfunction

  task automatic test_reset();
    exp_t got;
    rstN = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    got = {fnO, funct7O, aO, bO, rdO, illegalO};
    tests++;
    if (outValid !== 1'b0) begin
      failed++;
      $display("[TB] FAIL reset_valid got=%b exp=0", outValid);
    end
    tests++;
    if (got !== exp_t'(0)) begin
      failed++;
      $display("[TB] FAIL reset_fields got=%h exp=%h", got, exp_t'(0));
    end
    tests++;
    if (inReady !== 1'b1) begin
      failed++;
      $display("[TB] FAIL reset_in_ready got=%b exp=1", inReady);
    end
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_and_op();
    exp_t got, exp;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 5'd1, 32'd23);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 5'd2, 32'd11);
    applyStimulus(1'b1, 32'h0020F1B3, 1'b1, 1'b0, 5'd0, 32'h0);
    tests++;
    if (inReady !== 1'b1) begin
      failed++;
      $display("[TB] FAIL and_op_in_ready got=%b exp=1", inReady);
    end
    sbQ.push_back(mkExp(3'd7, 7'h00, 32'd23, 32'd11, 5'd3, 1'b0));
    for (int c = 0; c < 8 && sbQ.size() != 0; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
      if (outValid) begin
        got = {fnO, funct7O, aO, bO, rdO, illegalO};
        exp = sbQ.pop_front();
        tests++;
        if (got !== exp) begin
          failed++;
          $display("[TB] FAIL and_op got=%h exp=%h", got, exp);
        end
      end
    end
    tests++;
    if (sbQ.size() != 0) begin
      failed++;
      $display("[TB] FAIL and_op_timeout pending=%0d exp=0", sbQ.size());
      sbQ.delete();
    end
  endtask

  task automatic test_op_imm();
    logic [31:0] ins [5];
    exp_t        exps [5];
    exp_t        got, exp;
    ins[0] = 32'hFFF08293; exps[0] = mkExp(3'd0, 7'h00, 32'd23, 32'hFFFFFFFF, 5'd5, 1'b0);
    ins[1] = 32'h4030D293; exps[1] = mkExp(3'd5, 7'h20, 32'd23, 32'h00000403, 5'd5, 1'b0);
    ins[2] = 32'h00309293; exps[2] = mkExp(3'd1, 7'h00, 32'd23, 32'h00000003, 5'd5, 1'b0);
    ins[3] = 32'h123453B7; exps[3] = mkExp(3'd0, 7'h00, 32'd0,  32'h12345000, 5'd7, 1'b0);
    ins[4] = 32'h40109293; exps[4] = mkExp(3'd0, 7'h00, 32'd0,  32'd0,        5'd5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, ins[i], 1'b1, 1'b0, 5'd0, 32'h0);
      sbQ.push_back(exps[i]);
      for (int c = 0; c < 8 && sbQ.size() != 0; c++) begin
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        if (outValid) begin
          got = {fnO, funct7O, aO, bO, rdO, illegalO};
          exp = sbQ.pop_front();
          tests++;
          if (got !== exp) begin
            failed++;
            $display("[TB] FAIL op_imm[%0d] instr=%h got=%h exp=%h", i, ins[i], got, exp);
          end
        end
      end
      tests++;
      if (sbQ.size() != 0) begin
        failed++;
        $display("[TB] FAIL op_imm_timeout[%0d] pending=%0d exp=0", i, sbQ.size());
        sbQ.delete();
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] ins [2];
    logic [4:0]  wbr [2];
    logic [31:0] wbd [2];
    exp_t        exps [2];
    exp_t        got, exp;
    ins[0] = 32'h00108233; wbr[0] = 5'd1; wbd[0] = 32'd99;
    exps[0] = mkExp(3'd0, 7'h00, 32'd99, 32'd99, 5'd4, 1'b0);
    ins[1] = 32'h00000333; wbr[1] = 5'd0; wbd[1] = 32'd55;
    exps[1] = mkExp(3'd0, 7'h00, 32'd0, 32'd0, 5'd6, 1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, ins[i], 1'b1, 1'b1, wbr[i], wbd[i]);
      sbQ.push_back(exps[i]);
      for (int c = 0; c < 8 && sbQ.size() != 0; c++) begin
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        if (outValid) begin
          got = {fnO, funct7O, aO, bO, rdO, illegalO};
          exp = sbQ.pop_front();
          tests++;
          if (got !== exp) begin
            failed++;
            $display("[TB] FAIL bypass[%0d] got=%h exp=%h", i, got, exp);
          end
        end
      end
      tests++;
      if (sbQ.size() != 0) begin
        failed++;
        $display("[TB] FAIL bypass_timeout[%0d] pending=%0d exp=0", i, sbQ.size());
        sbQ.delete();
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t got, exp;
    // x1 now holds 99 (bypass write) and x2 holds 11.
    applyStimulus(1'b1, 32'h00208433, 1'b0, 1'b0, 5'd0, 32'h0);
    tests++;
    if (inReady !== 1'b1) begin
      failed++;
      $display("[TB] FAIL bp_first_accept got=%b exp=1", inReady);
    end
    sbQ.push_back(mkExp(3'd0, 7'h00, 32'd99, 32'd11, 5'd8, 1'b0));
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 32'h0020F4B3, 1'b0, 1'b0, 5'd0, 32'h0);
      got = {fnO, funct7O, aO, bO, rdO, illegalO};
      tests++;
      if (inReady !== 1'b0) begin
        failed++;
        $display("[TB] FAIL bp_in_ready[%0d] got=%b exp=0", c, inReady);
      end
      tests++;
      if ((outValid !== 1'b1) || (got !== sbQ[0])) begin
        failed++;
        $display("[TB] FAIL bp_hold[%0d] valid=%b got=%h exp=%h", c, outValid, got, sbQ[0]);
      end
    end
    applyStimulus(1'b1, 32'h0020F4B3, 1'b1, 1'b0, 5'd0, 32'h0);
    tests++;
    if (inReady !== 1'b1) begin
      failed++;
      $display("[TB] FAIL bp_release_in_ready got=%b exp=1", inReady);
    end
    tests++;
    if (outValid !== 1'b1) begin
      failed++;
      $display("[TB] FAIL bp_release_valid got=%b exp=1", outValid);
    end else begin
      got = {fnO, funct7O, aO, bO, rdO, illegalO};
      exp = sbQ.pop_front();
      if (got !== exp) begin
        failed++;
        $display("[TB] FAIL bp_first got=%h exp=%h", got, exp);
      end
    end
    sbQ.push_back(mkExp(3'd7, 7'h00, 32'd99, 32'd11, 5'd9, 1'b0));
    for (int c = 0; c < 8 && sbQ.size() != 0; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
      if (outValid) begin
        got = {fnO, funct7O, aO, bO, rdO, illegalO};
        exp = sbQ.pop_front();
        tests++;
        if (got !== exp) begin
          failed++;
          $display("[TB] FAIL bp_second got=%h exp=%h", got, exp);
        end
      end
    end
    tests++;
    if (sbQ.size() != 0) begin
      failed++;
      $display("[TB] FAIL bp_timeout pending=%0d exp=0", sbQ.size());
      sbQ.delete();
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
    tests++;
    if (outValid !== 1'b0) begin
      failed++;
      $display("[TB] FAIL bp_no_duplicate got=%b exp=0", outValid);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins [3];
    exp_t        exps [3];
    exp_t        got, exp;
    ins[0] = 32'h0000007F; exps[0] = mkExp(3'd0, 7'h00, 32'd0,  32'd0,  5'd0, 1'b1);
    ins[1] = 32'h4020F1B3; exps[1] = mkExp(3'd0, 7'h00, 32'd0,  32'd0,  5'd3, 1'b1);
    ins[2] = 32'h402081B3; exps[2] = mkExp(3'd0, 7'h20, 32'd99, 32'd11, 5'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, ins[i], 1'b1, 1'b0, 5'd0, 32'h0);
      sbQ.push_back(exps[i]);
      for (int c = 0; c < 8 && sbQ.size() != 0; c++) begin
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        if (outValid) begin
          got = {fnO, funct7O, aO, bO, rdO, illegalO};
          exp = sbQ.pop_front();
          tests++;
          if (got !== exp) begin
            failed++;
            $display("[TB] FAIL illegal[%0d] instr=%h got=%h exp=%h", i, ins[i], got, exp);
          end
        end
      end
      tests++;
      if (sbQ.size() != 0) begin
        failed++;
        $display("[TB] FAIL illegal_timeout[%0d] pending=%0d exp=0", i, sbQ.size());
        sbQ.delete();
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t got, exp;
    applyStimulus(1'b1, 32'h0020F1B3, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    tests++;
    if (outValid !== 1'b1) begin
      failed++;
      $display("[TB] FAIL rst_mid_pre_valid got=%b exp=1", outValid);
    end
    rstN = 1'b0;
    #1;
    tests++;
    if (outValid !== 1'b0) begin
      failed++;
      $display("[TB] FAIL rst_mid_async_valid got=%b exp=0", outValid);
    end
    @(negedge clk);
    rstN = 1'b1;
    // Regfile was cleared, so x1 must read zero.
    applyStimulus(1'b1, 32'h00108233, 1'b1, 1'b0, 5'd0, 32'h0);
    sbQ.push_back(mkExp(3'd0, 7'h00, 32'd0, 32'd0, 5'd4, 1'b0));
    for (int c = 0; c < 8 && sbQ.size() != 0; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
      if (outValid) begin
        got = {fnO, funct7O, aO, bO, rdO, illegalO};
        exp = sbQ.pop_front();
        tests++;
        if (got !== exp) begin
          failed++;
          $display("[TB] FAIL rst_mid_regfile got=%h exp=%h", got, exp);
        end
      end
    end
    tests++;
    if (sbQ.size() != 0) begin
      failed++;
      $display("[TB] FAIL rst_mid_timeout pending=%0d exp=0", sbQ.size());
      sbQ.delete();
    end
  endtask

  // Test sequence; each scenario leaves the pipeline drained for the next.
  initial begin
    rstN     = 1'b0;
    inValid  = 1'b0;
    instr    = 32'h0;
    outReady = 1'b0;
    wbEn     = 1'b0;
    wbRd     = 5'd0;
    wbData   = 32'h0;
    test_reset();
    test_and_op();
    test_op_imm();
    test_bypass();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
